// File: rtl/opp_packet_rx_if.sv
// Byte stream from the link receive path into the opponent-state deframer.
// Latency: n/a; no backpressure (the sink accepts every valid beat).
interface opp_packet_rx_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;

    modport master (output in_valid, output in_data, output in_last);
    modport slave  (input  in_valid, input  in_data, input  in_last);
endinterface

// File: rtl/opp_packet_rx.sv
// Deframes 7-byte opponent-state frames into registered position/heading/status, with link-stale flag.
// Latency: outputs and receive_axiiv one cycle after the B6 beat; no backpressure, every beat consumed.
module opp_packet_rx #(
    parameter logic [7:0] MAGIC        = 8'hA5,
    parameter int         GAP_TIMEOUT  = 64,
    parameter int         STALE_CYCLES = 4_000_000
) (
    input  logic               clk,
    input  logic               rst,
    opp_packet_rx_if.slave     rx,
    output logic [10:0]        r_opp_x,
    output logic [10:0]        r_opp_y,
    output logic [8:0]         r_opp_dir,
    output logic [2:0]         r_opp_game,
    output logic               r_opp_rst,
    output logic               receive_axiiv,
    output logic               opp_stale,
    output logic [7:0]         frames_ok,
    output logic [7:0]         frames_bad
);

    localparam int GAP_W   = $clog2(GAP_TIMEOUT + 1);
    localparam int STALE_W = $clog2(STALE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         chk_q, chk_d;
    logic [47:0]        hold_q, hold_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [STALE_W-1:0] stale_q;
    logic               accept;
    logic               bad_inc;

    logic               beat;
    logic [7:0]         data;
    logic               gap_expired;

    // At the B6 beat the low 40 bits of the holding register are B1..B5.
    logic [10:0]        dec_x;
    logic [10:0]        dec_y;
    logic [8:0]         dec_dir;
    logic [2:0]         dec_game;
    logic               dec_rst;
    logic               unused_hold_bits;

    assign beat        = rx.in_valid;
    assign data        = rx.in_data;
    assign gap_expired = (gap_q == GAP_W'(GAP_TIMEOUT - 1));

    assign dec_x    = hold_q[39:29];
    assign dec_y    = hold_q[28:18];
    assign dec_dir  = hold_q[17:9];
    assign dec_game = hold_q[8:6];
    assign dec_rst  = hold_q[5];
    assign unused_hold_bits = ^{hold_q[47:40], hold_q[4:0]};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        accept  = 1'b0;
        bad_inc = 1'b0;

        case (state_q)
            IDLE: begin
                gap_d = '0;
                if (beat) begin
                    if (data == MAGIC && !rx.in_last) begin
                        state_d = BODY;
                        idx_d   = 3'd1;
                        chk_d   = MAGIC;
                    end else begin
                        bad_inc = 1'b1;
                        if (!rx.in_last) begin
                            state_d = DROP;
                        end
                    end
                end
            end

            BODY: begin
                if (beat) begin
                    gap_d  = '0;
                    hold_d = {hold_q[39:0], data};
                    chk_d  = chk_q ^ data;
                    idx_d  = idx_q + 3'd1;
                    if (idx_q == 3'd6) begin
                        idx_d = '0;
                        if (rx.in_last) begin
                            state_d = IDLE;
                            if (chk_q == data && dec_dir < 9'd360) begin
                                accept = 1'b1;
                            end else begin
                                bad_inc = 1'b1;
                            end
                        end else begin
                            state_d = DROP;
                            bad_inc = 1'b1;
                        end
                    end else if (rx.in_last) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        bad_inc = 1'b1;
                    end
                end else if (gap_expired) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    gap_d   = '0;
                    bad_inc = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            DROP: begin
                if (beat) begin
                    gap_d = '0;
                    if (rx.in_last) begin
                        state_d = IDLE;
                    end
                end else if (gap_expired) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                idx_d   = '0;
                gap_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            chk_q   <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
        end
    end

    // Opponent state only ever changes on a fully validated frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opp_x       <= 11'd300;
            r_opp_y       <= 11'd100;
            r_opp_dir     <= 9'd90;
            r_opp_game    <= 3'd0;
            r_opp_rst     <= 1'b0;
            receive_axiiv <= 1'b0;
        end else begin
            receive_axiiv <= accept;
            if (accept) begin
                r_opp_x    <= dec_x;
                r_opp_y    <= dec_y;
                r_opp_dir  <= dec_dir;
                r_opp_game <= dec_game;
                r_opp_rst  <= dec_rst;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_ok  <= '0;
            frames_bad <= '0;
        end else begin
            if (accept && frames_ok != 8'hFF) begin
                frames_ok <= frames_ok + 8'd1;
            end
            if (bad_inc && frames_bad != 8'hFF) begin
                frames_bad <= frames_bad + 8'd1;
            end
        end
    end

    // Accept wins over saturation, so a frame arriving on the boundary keeps opp_stale low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stale_q <= '0;
        end else if (accept) begin
            stale_q <= '0;
        end else if (stale_q != STALE_W'(STALE_CYCLES)) begin
            stale_q <= stale_q + 1'b1;
        end
    end

    assign opp_stale = (stale_q == STALE_W'(STALE_CYCLES));

endmodule

// File: tb/tb_opp_packet_rx.sv
// Directed bench for opp_packet_rx: good/bad frames, length and gap errors, stale flag, mid-frame reset.
module tb_opp_packet_rx;

    logic        clk;
    logic        rst;
    logic [10:0] r_opp_x;
    logic [10:0] r_opp_y;
    logic [8:0]  r_opp_dir;
    logic [2:0]  r_opp_game;
    logic        r_opp_rst;
    logic        receive_axiiv;
    logic        opp_stale;
    logic [7:0]  frames_ok;
    logic [7:0]  frames_bad;

    int errs   = 0;
    int checks = 0;

    opp_packet_rx_if rx ();

    opp_packet_rx #(
        .MAGIC        (8'hA5),
        .GAP_TIMEOUT  (64),
        .STALE_CYCLES (100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .r_opp_x       (r_opp_x),
        .r_opp_y       (r_opp_y),
        .r_opp_dir     (r_opp_dir),
        .r_opp_game    (r_opp_game),
        .r_opp_rst     (r_opp_rst),
        .receive_axiiv (receive_axiiv),
        .opp_stale     (opp_stale),
        .frames_ok     (frames_ok),
        .frames_bad    (frames_bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [55:0] mk_frame(input logic [10:0] x, input logic [10:0] y,
                                             input logic [8:0] d, input logic [2:0] g,
                                             input logic r);
        logic [7:0] b0, b1, b2, b3, b4, b5, b6;
        b0 = 8'hA5;
        b1 = x[10:3];
        b2 = {x[2:0], y[10:6]};
        b3 = {y[5:0], d[8:7]};
        b4 = {d[6:0], g[2]};
        b5 = {g[1:0], r, 5'b0};
        b6 = b0 ^ b1 ^ b2 ^ b3 ^ b4 ^ b5;
        return {b0, b1, b2, b3, b4, b5, b6};
    endfunction

    // One byte per call; returns on the negedge after the consuming posedge.
    task automatic beat(input logic [7:0] d, input logic l);
        rx.in_valid = 1'b1;
        rx.in_data  = d;
        rx.in_last  = l;
        @(negedge clk);
        rx.in_valid = 1'b0;
        rx.in_last  = 1'b0;
    endtask

    // Bytes lo..hi of the frame (index 7+ sends zero fill); in_last on byte last_at.
    task automatic send(input logic [55:0] f, input int lo, input int hi, input int last_at);
        logic [7:0] b;
        for (int i = lo; i <= hi; i++) begin
            b = (i < 7) ? f[8*(6-i) +: 8] : 8'h00;
            beat(b, i == last_at);
        end
    endtask

    logic [55:0] f_good, f_bad, f_360, f_359, f_g1, f_g2;

    initial begin
        rst         = 1'b1;
        rx.in_valid = 1'b0;
        rx.in_data  = 8'h00;
        rx.in_last  = 1'b0;

        f_good = mk_frame(11'd1000, 11'd1500, 9'd270, 3'd1, 1'b0);
        f_bad  = f_good ^ 56'h01;
        f_360  = mk_frame(11'd12, 11'd34, 9'd360, 3'd2, 1'b1);
        f_359  = mk_frame(11'd12, 11'd34, 9'd359, 3'd2, 1'b1);
        f_g1   = mk_frame(11'd77, 11'd88, 9'd10, 3'd3, 1'b0);
        f_g2   = mk_frame(11'd500, 11'd600, 9'd180, 3'd4, 1'b0);

        repeat (2) @(negedge clk);
        check("rst_x", r_opp_x, 300);
        check("rst_y", r_opp_y, 100);
        check("rst_dir", r_opp_dir, 90);
        check("rst_game", r_opp_game, 0);
        check("rst_orst", r_opp_rst, 0);
        check("rst_pulse", receive_axiiv, 0);
        check("rst_stale", opp_stale, 0);
        check("rst_ok", frames_ok, 0);
        check("rst_bad", frames_bad, 0);

        rst = 1'b0;
        repeat (99) @(negedge clk);
        check("stale_99", opp_stale, 0);
        @(negedge clk);
        check("stale_100", opp_stale, 1);

        // Corrupted checksum, then the same frame intact right behind it.
        send(f_bad, 0, 6, 6);
        check("badchk_pulse", receive_axiiv, 0);
        check("badchk_x", r_opp_x, 300);
        check("badchk_y", r_opp_y, 100);
        check("badchk_dir", r_opp_dir, 90);
        check("badchk_bad", frames_bad, 1);
        check("badchk_ok", frames_ok, 0);
        send(f_good, 0, 6, 6);
        check("good_pulse", receive_axiiv, 1);
        check("good_x", r_opp_x, 1000);
        check("good_y", r_opp_y, 1500);
        check("good_dir", r_opp_dir, 270);
        check("good_game", r_opp_game, 1);
        check("good_orst", r_opp_rst, 0);
        check("good_ok", frames_ok, 1);
        check("good_stale", opp_stale, 0);
        @(negedge clk);
        check("good_pulse_end", receive_axiiv, 0);

        send(f_good, 0, 3, 3);
        check("short_bad", frames_bad, 2);
        check("short_pulse", receive_axiiv, 0);
        send(f_good, 0, 7, 7);
        check("long_bad", frames_bad, 3);
        check("long_ok", frames_ok, 1);

        send(f_360, 0, 6, 6);
        check("dir360_bad", frames_bad, 4);
        check("dir360_pulse", receive_axiiv, 0);
        check("dir360_x", r_opp_x, 1000);
        send(f_359, 0, 6, 6);
        check("dir359_pulse", receive_axiiv, 1);
        check("dir359_ok", frames_ok, 2);
        check("dir359_dir", r_opp_dir, 359);
        check("dir359_x", r_opp_x, 12);
        check("dir359_y", r_opp_y, 34);
        check("dir359_game", r_opp_game, 2);
        check("dir359_orst", r_opp_rst, 1);

        // Stall after B2 long enough to time out.
        send(f_g1, 0, 2, -1);
        repeat (63) @(negedge clk);
        check("gap63_bad", frames_bad, 4);
        @(negedge clk);
        check("gap64_bad", frames_bad, 5);
        send(f_g1, 0, 6, 6);
        check("after_gap_ok", frames_ok, 3);
        check("after_gap_x", r_opp_x, 77);

        // Stall one cycle short of the timeout, then finish the frame.
        send(f_g2, 0, 2, -1);
        repeat (63) @(negedge clk);
        send(f_g2, 3, 6, 6);
        check("stall63_pulse", receive_axiiv, 1);
        check("stall63_ok", frames_ok, 4);
        check("stall63_bad", frames_bad, 5);
        check("stall63_x", r_opp_x, 500);
        check("stall63_dir", r_opp_dir, 180);

        // Reset mid-frame, then the tail of that frame must not be accepted.
        send(f_good, 0, 3, -1);
        #2 rst = 1'b1;
        #1;
        check("midrst_x", r_opp_x, 300);
        check("midrst_dir", r_opp_dir, 90);
        check("midrst_ok", frames_ok, 0);
        check("midrst_bad", frames_bad, 0);
        @(negedge clk);
        rst = 1'b0;
        send(f_good, 4, 6, 6);
        check("tail_pulse", receive_axiiv, 0);
        check("tail_ok", frames_ok, 0);
        check("tail_bad", frames_bad, 1);
        check("tail_x", r_opp_x, 300);
        send(f_good, 0, 6, 6);
        check("post_rst_ok", frames_ok, 1);
        check("post_rst_x", r_opp_x, 1000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
